// File: rtl/uart_link.sv
// uart_link: full-duplex UART transceiver with runtime baud rate,
// optional even parity and 1/2 stop bits. Line settings are latched at
// the start of each frame so changes mid-frame do not disturb it.
module uart_link #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_busy_o,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_busy_o,
  output logic        tx_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  localparam logic [31:0] CLK_F = 32'(CLK_FREQ);

  // Bit period; divisor forced to 1 when disabled so the divide is never by zero,
  // and the quotient clamped to 1 so counters always terminate.
  logic [31:0] w_den, w_quo, w_div;
  logic        w_en;
  assign w_en  = (baudrate_i != 17'd0);
  assign w_den = w_en ? {15'd0, baudrate_i} : 32'd1;
  assign w_quo = CLK_F / w_den;
  assign w_div = (w_quo == 32'd0) ? 32'd1 : w_quo;

  // ---------------- TX ----------------
  state_t      r_tx_state;
  logic [31:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_bit;
  logic        r_tx_par, r_tx_par_en, r_tx_stop2, r_tx_stop_idx;
  logic        r_tx, r_tx_busy;

  // TX frame sequencer: each state holds its bit on the line for one bit period
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_tx_state    <= S_IDLE;
      r_tx_cnt      <= 32'd0;
      r_tx_div      <= 32'd1;
      r_tx_sh       <= 8'h00;
      r_tx_bit      <= 3'd0;
      r_tx_par      <= 1'b0;
      r_tx_par_en   <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_idx <= 1'b0;
      r_tx          <= 1'b1;
      r_tx_busy     <= 1'b0;
    end else if (r_tx_state == S_IDLE) begin
      if (tx_valid_i && w_en) begin
        r_tx_state  <= S_START;
        r_tx        <= 1'b0;
        r_tx_busy   <= 1'b1;
        r_tx_cnt    <= 32'd0;
        r_tx_div    <= w_div;
        r_tx_par_en <= parity_en_i;
        r_tx_stop2  <= stopbit_i;
        r_tx_sh     <= tx_data_i;
        r_tx_par    <= ^tx_data_i;
      end
    end else if (r_tx_cnt != r_tx_div - 32'd1) begin
      r_tx_cnt <= r_tx_cnt + 32'd1;
    end else begin
      r_tx_cnt <= 32'd0;
      case (r_tx_state)
        S_START: begin
          r_tx_state <= S_DATA;
          r_tx_bit   <= 3'd0;
          r_tx       <= r_tx_sh[0];
          r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
        end
        S_DATA: begin
          if (r_tx_bit == 3'd7) begin
            r_tx_stop_idx <= 1'b0;
            if (r_tx_par_en) begin
              r_tx_state <= S_PAR;
              r_tx       <= r_tx_par;
            end else begin
              r_tx_state <= S_STOP;
              r_tx       <= 1'b1;
            end
          end else begin
            r_tx_bit <= r_tx_bit + 3'd1;
            r_tx     <= r_tx_sh[0];
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
          end
        end
        S_PAR: begin
          r_tx_state    <= S_STOP;
          r_tx          <= 1'b1;
          r_tx_stop_idx <= 1'b0;
        end
        S_STOP: begin
          if (r_tx_stop_idx == r_tx_stop2) begin
            r_tx_state <= S_IDLE;
            r_tx_busy  <= 1'b0;
          end else begin
            r_tx_stop_idx <= 1'b1;
          end
        end
        default: begin
          r_tx_state <= S_IDLE;
          r_tx_busy  <= 1'b0;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o      = r_tx;
  assign tx_busy_o = r_tx_busy;

  // ---------------- RX ----------------
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  logic w_rx_fall;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Edge rather than level, so a line held low after a framing error cannot retrigger
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;

  state_t      r_rx_state;
  logic [31:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_sh, r_rx_data;
  logic [2:0]  r_rx_bit;
  logic        r_rx_par, r_rx_par_en, r_rx_stop2, r_rx_stop_idx, r_rx_err;
  logic        r_rx_valid, r_rx_busy;

  // RX frame sequencer: mid-start recheck, then one sample per bit period
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rx_state    <= S_IDLE;
      r_rx_cnt      <= 32'd0;
      r_rx_div      <= 32'd1;
      r_rx_sh       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_bit      <= 3'd0;
      r_rx_par      <= 1'b0;
      r_rx_par_en   <= 1'b0;
      r_rx_stop2    <= 1'b0;
      r_rx_stop_idx <= 1'b0;
      r_rx_err      <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall && w_en) begin
            r_rx_state  <= S_START;
            r_rx_busy   <= 1'b1;
            r_rx_cnt    <= 32'd0;
            r_rx_div    <= w_div;
            r_rx_par_en <= parity_en_i;
            r_rx_stop2  <= stopbit_i;
          end
        end
        S_START: begin
          if (r_rx_cnt == {1'b0, r_rx_div[31:1]}) begin
            r_rx_cnt <= 32'd0;
            if (r_rx_s2) begin
              r_rx_state <= S_IDLE;
              r_rx_busy  <= 1'b0;
            end else begin
              r_rx_state <= S_DATA;
              r_rx_bit   <= 3'd0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
        default: begin
          if (r_rx_cnt != r_rx_div - 32'd1) begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end else begin
            r_rx_cnt <= 32'd0;
            if (r_rx_state == S_DATA) begin
              r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
              if (r_rx_bit == 3'd7) begin
                r_rx_state    <= r_rx_par_en ? S_PAR : S_STOP;
                r_rx_stop_idx <= 1'b0;
                r_rx_err      <= 1'b0;
              end else begin
                r_rx_bit <= r_rx_bit + 3'd1;
              end
            end else if (r_rx_state == S_PAR) begin
              r_rx_par      <= r_rx_s2;
              r_rx_state    <= S_STOP;
              r_rx_stop_idx <= 1'b0;
              r_rx_err      <= 1'b0;
            end else if (r_rx_state == S_STOP) begin
              if (r_rx_stop_idx == r_rx_stop2) begin
                if (!r_rx_err && r_rx_s2 && (!r_rx_par_en || (r_rx_par == ^r_rx_sh))) begin
                  r_rx_data  <= r_rx_sh;
                  r_rx_valid <= 1'b1;
                end
                r_rx_state <= S_IDLE;
                r_rx_busy  <= 1'b0;
              end else begin
                r_rx_err      <= ~r_rx_s2;
                r_rx_stop_idx <= 1'b1;
              end
            end else begin
              r_rx_state <= S_IDLE;
              r_rx_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign rx_busy_o  = r_rx_busy;

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: loopback / injected-frame bench for uart_link with a
// scoreboard of expected received bytes. The clock is scaled to 10 MHz so
// that 115200 baud gives an 86-cycle bit and the run stays short.
module tb_uart_link;
  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;  // 86
  localparam int FRAME    = 12 * DIV;         // parity + 2 stop bits

  logic        clk = 1'b0;
  logic        resetn;
  logic [16:0] baud;
  logic        parity_en, stopbit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        inj_mode, inj;
  logic        rx_line;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, rx_busy_o, tx_busy_o, tx_o;

  assign rx_line = inj_mode ? inj : tx_o;

  uart_link #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk_i(clk), .resetn_i(resetn), .baudrate_i(baud),
    .parity_en_i(parity_en), .stopbit_i(stopbit), .rx_i(rx_line),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_busy_o(rx_busy_o),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_busy_o(tx_busy_o), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_pulse = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    while (tx_busy_o !== val && n < 20000) begin step(1); n++; end
    chk(tag, {31'd0, tx_busy_o}, {31'd0, val});
  endtask

  // Count idle cycles between two back-to-back frames
  task automatic gap_check(input string tag);
    int n = 0;
    while (!tx_busy_o && n < 100) begin n++; step(1); end
    chk(tag, n, 1);
    chk({tag, "_start"}, {31'd0, tx_o}, 0);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3 * FRAME) begin step(1); n++; end
    chk({tag, "_rx_drain"}, exp_q.size(), 0);
  endtask

  // Drive one frame directly onto rx_i (parity on, 2 stop bits)
  task automatic send_raw(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    inj = 1'b0; step(DIV);
    for (int i = 0; i < 8; i++) begin inj = d[i]; step(DIV); end
    inj = (^d) ^ bad_par; step(DIV);
    inj = ~bad_stop; step(2 * DIV);
    inj = 1'b1; step(DIV);
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (resetn === 1'b1 && rx_valid_o === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, rx_data_o}, 32'h100);
      else chk("rx_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int n, p0;
    resetn = 1'b1; baud = 17'(BAUD); parity_en = 1'b1; stopbit = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; inj_mode = 1'b0; inj = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("rst_tx_o", {31'd0, tx_o}, 1);
    chk("rst_tx_busy", {31'd0, tx_busy_o}, 0);
    chk("rst_rx_busy", {31'd0, rx_busy_o}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid_o}, 0);
    chk("rst_rx_data", {24'd0, rx_data_o}, 0);
    step(3);
    resetn = 1'b1;
    step(5);

    // Loopback single byte, busy length
    exp_q.push_back(8'hA5);
    tx_data = 8'hA5; tx_valid = 1'b1; step(1); tx_valid = 1'b0;
    chk("t1_busy_rise", {31'd0, tx_busy_o}, 1);
    chk("t1_start_bit", {31'd0, tx_o}, 0);
    n = 0;
    do begin n++; step(1); end while (tx_busy_o && n < 5000);
    chk("t1_busy_len", n, FRAME);
    wait_rx("t1");
    step(50);
    chk("t1_pulses", n_pulse, 1);

    // Back-to-back with a request while busy (0x77) that must be dropped
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    tx_data = 8'h00; tx_valid = 1'b1;
    wait_busy(1'b1, "t2_acc0");
    step(200); tx_data = 8'h77;
    step(200); tx_data = 8'hFF;
    wait_busy(1'b0, "t2_end0");
    gap_check("t2_gap0");
    tx_data = 8'h55;
    wait_busy(1'b0, "t2_end1");
    gap_check("t2_gap1");
    tx_valid = 1'b0;
    wait_busy(1'b0, "t2_end2");
    wait_rx("t2");
    chk("t2_pulses", n_pulse, 4);

    // Parity error then good frame
    inj_mode = 1'b1;
    p0 = n_pulse;
    send_raw(8'h3C, 1'b1, 1'b0);
    step(DIV);
    chk("t3_par_nopulse", n_pulse, p0);
    chk("t3_par_data", {24'd0, rx_data_o}, 32'h55);
    exp_q.push_back(8'h3C);
    send_raw(8'h3C, 1'b0, 1'b0);
    wait_rx("t3");

    // Framing error then good frame
    p0 = n_pulse;
    send_raw(8'h81, 1'b0, 1'b1);
    step(DIV);
    chk("t4_frm_nopulse", n_pulse, p0);
    chk("t4_frm_data", {24'd0, rx_data_o}, 32'h3C);
    exp_q.push_back(8'h42);
    send_raw(8'h42, 1'b0, 1'b0);
    wait_rx("t4");

    // Glitch shorter than half a bit
    p0 = n_pulse;
    inj = 1'b0; step(10);
    chk("t5_busy_rise", {31'd0, rx_busy_o}, 1);
    step(10); inj = 1'b1;
    step(60);
    chk("t5_busy_fall", {31'd0, rx_busy_o}, 0);
    chk("t5_nopulse", n_pulse, p0);

    // Reset halfway through a loopback frame
    inj_mode = 1'b0;
    p0 = n_pulse;
    tx_data = 8'h99; tx_valid = 1'b1; step(1); tx_valid = 1'b0;
    step(6 * DIV);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_tx_o", {31'd0, tx_o}, 1);
    chk("t6_rst_tx_busy", {31'd0, tx_busy_o}, 0);
    chk("t6_rst_rx_busy", {31'd0, rx_busy_o}, 0);
    step(3);
    resetn = 1'b1;
    step(FRAME);
    chk("t6_nopulse", n_pulse, p0);
    chk("t6_rx_data", {24'd0, rx_data_o}, 0);
    exp_q.push_back(8'h5A);
    tx_data = 8'h5A; tx_valid = 1'b1; step(1); tx_valid = 1'b0;
    wait_busy(1'b0, "t6_end");
    wait_rx("t6");

    // Disabled block ignores requests
    baud = 17'd0;
    tx_data = 8'h11; tx_valid = 1'b1; step(3);
    chk("t7_dis_busy", {31'd0, tx_busy_o}, 0);
    chk("t7_dis_tx_o", {31'd0, tx_o}, 1);
    tx_valid = 1'b0; baud = 17'(BAUD);
    step(10);

    chk("total_pulses", n_pulse, 7);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_link.md
# uart_link

Full-duplex UART transceiver for the `riscv_unit` SoC. It serializes bytes onto `tx_o` and deserializes bytes from `rx_i`, with a runtime-programmable baud rate, optional even parity and 1 or 2 stop bits. The SoC's boot/programming path and CoreMark console exchange all host traffic through it. It also serves as the bench-side peer: two instances with identical settings must interoperate.

## Interface
- `CLK_FREQ`, default 100_000_000: `clk_i` frequency in Hz, used to derive the bit period.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `resetn_i`  in  1  reset, asynchronous and active-low. This is the single clock and reset of the block; polarity and synchronicity are fixed.
- `baudrate_i`  in  17  baud rate in bit/s (e.g. 115200).
- `parity_en_i`  in  1  1 = append/check an even parity bit.
- `stopbit_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `rx_i`  in  1  serial input, asynchronous, idle high.
- `rx_data_o`  out  8  last correctly received byte.
- `rx_valid_o`  out  1  one-cycle pulse when `rx_data_o` is updated.
- `rx_busy_o`  out  1  receive frame in progress.
- `tx_data_i`  in  8  byte to transmit.
- `tx_valid_i`  in  1  transmit request.
- `tx_busy_o`  out  1  transmit frame in progress.
- `tx_o`  out  1  serial output, idle high.

## Operation
- Bit period: `DIV = CLK_FREQ / baudrate_i`, integer truncation, 32-bit arithmetic. This gives 868 cycles at 100 MHz and 115200 baud.
- If `baudrate_i == 0`, the block is disabled: `tx_valid_i` is ignored and RX stays idle.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits (1).
  - Parity bit = XOR of the 8 data bits (even parity).
- `baudrate_i`, `parity_en_i` and `stopbit_i` are latched at frame start. Changes during a frame do not affect that frame.
- TX FSM: IDLE → START → DATA(8) → PARITY (only if enabled) → STOP(1 or 2) → IDLE. Each state lasts DIV cycles.
  - A request is accepted when `tx_valid_i=1` and `tx_busy_o=0`; `tx_data_i` is latched at acceptance.
  - Requests while busy are ignored (not queued).
- RX path: `rx_i` passes through a 2-flop synchronizer.
  - RX FSM: IDLE → START → DATA(8) → PARITY (only if enabled) → STOP(1 or 2) → IDLE.
  - A falling edge in IDLE enters START.
  - At DIV/2 the start bit is re-sampled. If it is high, the frame is a glitch and the FSM returns to IDLE without asserting `rx_valid_o`.
  - All later bits are sampled every DIV cycles from that mid-start point.
  - After the last stop-bit sample:
    - if parity matches (when enabled) and all stop bits are 1, `rx_data_o` is loaded and `rx_valid_o` pulses;
    - otherwise the byte is dropped, `rx_data_o` keeps its old value, and there is no pulse.
  - The FSM then returns to IDLE and can detect the next start edge immediately.
- TX and RX are fully independent and may run simultaneously.

## Timing
- Reset values: `tx_o=1`, `tx_busy_o=0`, `rx_busy_o=0`, `rx_valid_o=0`, `rx_data_o=8'h00`. Both FSMs go to IDLE and the synchronizer flops go to 1.
- Reset mid-frame aborts immediately. `tx_o` returns high asynchronously and no partial byte is reported.
- TX:
  - `tx_busy_o` and `tx_o=0` (start bit) take effect on the clock edge that accepts the request.
  - `tx_o` holds the last stop bit for DIV cycles. `tx_busy_o` deasserts in the same cycle the frame ends.
  - A new request on the first idle cycle starts the next frame with no gap.
  - Frame length = (1 + 8 + parity_en + 1 + stopbit) × DIV cycles.
- RX:
  - `rx_busy_o` rises 3 cycles after the falling edge on `rx_i` (2 synchronizer cycles + 1 register).
  - `rx_busy_o` falls together with the one-cycle `rx_valid_o` pulse, which is the cycle after the last stop-bit sample.
  - `rx_data_o` is stable from the pulse until the next valid frame.

## Test plan
- Loopback (`tx_o`→`rx_i`), 100 MHz, 115200, parity on, 2 stop bits; send 0xA5 → exactly one `rx_valid_o` pulse with `rx_data_o=0xA5`; `tx_busy_o` high for 12×868=10416 cycles.
- Back-to-back: send 0x00, 0xFF, 0x55 by re-asserting `tx_valid_i` on the first idle cycle → received in order, no idle gap on `tx_o`. A request issued while busy is dropped.
- Parity error: inject a frame 0x3C with an inverted parity bit → no `rx_valid_o`, `rx_data_o` unchanged. A following good frame 0x3C is received.
- Framing error: stop bit driven 0 → no valid pulse; RX recovers on the next good frame.
- Glitch: `rx_i` low for 100 cycles (< DIV/2) → `rx_busy_o` returns low, no valid pulse.
- Reset mid-frame: assert `resetn_i=0` halfway through a TX frame → `tx_o=1` and `tx_busy_o=0` at once; no byte is received; a new transfer after reset release succeeds.
